// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: word-aligned byte-enabled req/ack bus, load extraction, timeout.
// Optional `MEM_ALIGN_CHECK_EN: misaligned word/halfword accesses raise err without a bus request.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_pc,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [31:0] o_err_pc,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [2:0] OpLh  = 3'b001;
    localparam logic [2:0] OpLhu = 3'b010;
    localparam logic [2:0] OpLb  = 3'b011;
    localparam logic [2:0] OpLbu = 3'b100;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_t;
    typedef enum logic [1:0] {SzWord, SzHalf, SzByte} size_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic [31:0] r_pc;

    size_t       w_size;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Request decode works on the live inputs so it can be registered on the IDLE->REQ edge.
    always_comb begin
        w_size = SzWord;
        w_we   = 1'b0;
        case (i_op)
            3'b001, 3'b010: w_size = SzHalf;
            3'b011, 3'b100: w_size = SzByte;
            3'b101: w_we = 1'b1;
            3'b110: begin w_size = SzHalf; w_we = 1'b1; end
            3'b111: begin w_size = SzByte; w_we = 1'b1; end
            default: w_size = SzWord;
        endcase
        case (w_size)
            SzHalf: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            SzByte: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = ((w_size == SzWord) && (i_addr[1:0] != 2'b00)) ||
                          ((w_size == SzHalf) && i_addr[0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // Lane selection uses the captured offset; mem_rdata is only meaningful with mem_ack.
    always_comb begin
        case (r_off)
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            2'd3:    w_byte = i_mem_rdata[31:24];
            default: w_byte = i_mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_op)
            OpLh:    w_load = {{16{w_half[15]}}, w_half};
            OpLhu:   w_load = {16'h0000, w_half};
            OpLb:    w_load = {{24{w_byte[7]}}, w_byte};
            OpLbu:   w_load = {24'h000000, w_byte};
            default: w_load = i_mem_rdata;
        endcase
    end

    assign o_stall = ((r_state == StIdle) && i_start) || (r_state == StReq) || (r_state == StErr);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_op        <= '0;
            r_off       <= '0;
            r_pc        <= '0;
            o_done      <= 1'b0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_err_pc    <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_op  <= i_op;
                        r_off <= i_addr[1:0];
                        r_pc  <= i_pc;
                        r_cnt <= '0;
                        if (w_misaligned) begin
                            r_state  <= StErr;
                            o_err    <= 1'b1;
                            o_err_pc <= i_pc;
                        end else begin
                            r_state     <= StReq;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= w_we;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_be    <= w_be;
                            o_mem_wdata <= w_wdata;
                        end
                    end
                end
                StReq: begin
                    if (i_mem_ack) begin
                        r_state   <= StResp;
                        o_mem_req <= 1'b0;
                        o_done    <= 1'b1;
                        if (!o_mem_we) begin
                            o_rdata <= w_load;
                        end
                    end else if (r_cnt == 16'(TIMEOUT - 1)) begin
                        r_state   <= StErr;
                        o_mem_req <= 1'b0;
                        o_err     <= 1'b1;
                        o_err_pc  <= r_pc;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                StResp:  r_state <= StIdle;
                StErr:   r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scoreboard queues for load results and error PCs.
module tb_mem_access_unit;

    localparam logic [2:0] OpLw = 3'b000, OpLh = 3'b001, OpLhu = 3'b010, OpLb = 3'b011;
    localparam logic [2:0] OpLbu = 3'b100, OpSw = 3'b101, OpSh = 3'b110, OpSb = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_addr, i_wdata, i_pc;
    logic        o_stall, o_done, o_err, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_err_pc, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    typedef struct packed {
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] err_q[$];
    exp_t        mon_e;
    logic [31:0] mon_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_req, cap_stable, cap_stall0, cap_stall1, cap_done;
    logic        cap_stall_resp, cap_early;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_pc       (i_pc),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_err      (o_err),
        .o_err_pc   (o_err_pc),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_be   (o_mem_be),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_ack  (i_mem_ack),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    // Scoreboard monitors: every done/err pulse must match a pending expectation.
    always @(negedge clk) begin
        if (!rst && o_done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got done=1, required no done");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk && (o_rdata !== mon_e.rdata)) begin
                    n_fail++;
                    $display("FAIL load_rdata: got %08h, required %08h", o_rdata, mon_e.rdata);
                end
            end
        end
        if (!rst && o_err) begin
            n_checks++;
            if (err_q.size() == 0) begin
                n_fail++;
                $display("FAIL err_unexpected: got err=1, required no err");
            end else begin
                mon_pc = err_q.pop_front();
                if (o_err_pc !== mon_pc) begin
                    n_fail++;
                    $display("FAIL err_pc: got %08h, required %08h", o_err_pc, mon_pc);
                end
            end
        end
    end

    // Drives one access, holding start while stalled; ack arrives after `delay` wait cycles.
    task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] pc, input int delay, input logic [31:0] rword);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_addr = addr; i_wdata = wdata; i_pc = pc;
        #1 cap_stall0 = o_stall;
        @(negedge clk);
        cap_stall1 = o_stall; cap_req = o_mem_req; cap_we = o_mem_we;
        cap_addr = o_mem_addr; cap_be = o_mem_be; cap_wdata = o_mem_wdata;
        cap_stable = 1'b1; cap_early = 1'b0;
        for (int k = 0; k < delay; k++) begin
            i_mem_rdata = $urandom;
            @(negedge clk);
            if (o_mem_req !== 1'b1 || o_mem_we !== cap_we || o_mem_addr !== cap_addr ||
                o_mem_be !== cap_be || o_mem_wdata !== cap_wdata) cap_stable = 1'b0;
            if (o_done) cap_early = 1'b1;
        end
        i_mem_ack = 1'b1; i_mem_rdata = rword;
        @(negedge clk);
        i_mem_ack = 1'b0; i_start = 1'b0; i_mem_rdata = $urandom;
        cap_done = o_done;
        #1 cap_stall_resp = o_stall;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_start = 1'b0; i_op = '0; i_addr = '0; i_wdata = '0; i_pc = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_stall, o_done, o_err, o_mem_req, o_mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %05b, required 00000",
                     {o_stall, o_done, o_err, o_mem_req, o_mem_we});
        end
        n_checks++;
        if ({o_rdata, o_err_pc, o_mem_addr, o_mem_wdata, o_mem_be} !== 132'b0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%08h err_pc=%08h addr=%08h wdata=%08h be=%04b, required 0",
                     o_rdata, o_err_pc, o_mem_addr, o_mem_wdata, o_mem_be);
        end
        rst = 1'b0;
    endtask

    task automatic test_sw;
        exp_q.push_back('{chk: 1'b0, rdata: 32'h0});
        access(OpSw, 32'h10, 32'hDEADBEEF, 32'h1000, 0, 32'h0);
        n_checks++;
        if ({cap_req, cap_we, cap_addr, cap_be, cap_wdata} !== {2'b11, 32'h10, 4'b1111, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL sw_request: got req=%0b we=%0b addr=%08h be=%04b wdata=%08h, required 1 1 00000010 1111 deadbeef",
                     cap_req, cap_we, cap_addr, cap_be, cap_wdata);
        end
        n_checks++;
        if ({cap_stall0, cap_stall1, cap_done, cap_stall_resp} !== 4'b1110) begin
            n_fail++;
            $display("FAIL sw_timing: got stall0/stall1/done2/stall2=%04b, required 1110",
                     {cap_stall0, cap_stall1, cap_done, cap_stall_resp});
        end
    endtask

    task automatic test_byte;
        exp_q.push_back('{chk: 1'b0, rdata: 32'h0});
        access(OpSb, 32'h13, 32'h000000A5, 32'h1010, 0, 32'h0);
        n_checks++;
        if ({cap_we, cap_be, cap_wdata, cap_addr, cap_done} !== {1'b1, 4'b1000, 32'hA5A5A5A5, 32'h10, 1'b1}) begin
            n_fail++;
            $display("FAIL sb_request: got we=%0b be=%04b wdata=%08h addr=%08h done=%0b, required 1 1000 a5a5a5a5 00000010 1",
                     cap_we, cap_be, cap_wdata, cap_addr, cap_done);
        end
        exp_q.push_back('{chk: 1'b1, rdata: 32'hFFFFFFA5});
        access(OpLb, 32'h13, 32'h0, 32'h1014, 0, 32'hA5000000);
        n_checks++;
        if ({cap_we, cap_be, cap_done} !== {1'b0, 4'b1000, 1'b1}) begin
            n_fail++;
            $display("FAIL lb_request: got we=%0b be=%04b done=%0b, required 0 1000 1",
                     cap_we, cap_be, cap_done);
        end
        exp_q.push_back('{chk: 1'b1, rdata: 32'h000000A5});
        access(OpLbu, 32'h13, 32'h0, 32'h1018, 0, 32'hA5000000);
        exp_q.push_back('{chk: 1'b1, rdata: 32'h0000007F});
        access(OpLb, 32'h12, 32'h0, 32'h101C, 1, 32'h007F0000);
        n_checks++;
        if (cap_be !== 4'b0100) begin
            n_fail++;
            $display("FAIL lb_be_lane2: got %04b, required 0100", cap_be);
        end
    endtask

    task automatic test_half;
        exp_q.push_back('{chk: 1'b0, rdata: 32'h0});
        access(OpSh, 32'h22, 32'h1234BEEF, 32'h2000, 0, 32'h0);
        n_checks++;
        if ({cap_be, cap_wdata, cap_addr} !== {4'b1100, 32'hBEEFBEEF, 32'h20}) begin
            n_fail++;
            $display("FAIL sh_request: got be=%04b wdata=%08h addr=%08h, required 1100 beefbeef 00000020",
                     cap_be, cap_wdata, cap_addr);
        end
        exp_q.push_back('{chk: 1'b1, rdata: 32'hFFFF8001});
        access(OpLh, 32'h22, 32'h0, 32'h2004, 3, 32'h80011234);
        n_checks++;
        if ({cap_be, cap_stable, cap_early, cap_done} !== {4'b1100, 3'b101}) begin
            n_fail++;
            $display("FAIL lh_wait: got be=%04b stable=%0b early_done=%0b done=%0b, required 1100 1 0 1",
                     cap_be, cap_stable, cap_early, cap_done);
        end
        exp_q.push_back('{chk: 1'b1, rdata: 32'h00008001});
        access(OpLhu, 32'h22, 32'h0, 32'h2008, 2, 32'h80011234);
        exp_q.push_back('{chk: 1'b1, rdata: 32'h00001234});
        access(OpLh, 32'h20, 32'h0, 32'h200C, 0, 32'h80011234);
        n_checks++;
        if (cap_be !== 4'b0011) begin
            n_fail++;
            $display("FAIL lh_be_low: got %04b, required 0011", cap_be);
        end
    endtask

    task automatic test_timeout;
        logic req_ok;
        req_ok = 1'b1;
        err_q.push_back(32'h3000);
        @(negedge clk);
        i_start = 1'b1; i_op = OpLw; i_addr = 32'h40; i_pc = 32'h3000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_mem_req !== 1'b1 || o_err !== 1'b0) req_ok = 1'b0;
        end
        n_checks++;
        if (!req_ok) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got req/err wrong in REQ cycles 1-4, required req=1 err=0");
        end
        @(negedge clk);
        i_start = 1'b0;
        #1;
        n_checks++;
        if ({o_err, o_mem_req, o_done, o_stall} !== 4'b1001) begin
            n_fail++;
            $display("FAIL timeout_err_cycle: got err/req/done/stall=%04b, required 1001",
                     {o_err, o_mem_req, o_done, o_stall});
        end
        @(negedge clk);
        n_checks++;
        if ({o_err, o_mem_req, o_stall, o_err_pc} !== {3'b000, 32'h3000}) begin
            n_fail++;
            $display("FAIL timeout_after: got err=%0b req=%0b stall=%0b err_pc=%08h, required 0 0 0 00003000",
                     o_err, o_mem_req, o_stall, o_err_pc);
        end
    endtask

    task automatic test_misaligned;
`ifdef MEM_ALIGN_CHECK_EN
        err_q.push_back(32'h3004);
        @(negedge clk);
        i_start = 1'b1; i_op = OpLw; i_addr = 32'h101; i_pc = 32'h3004;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        n_checks++;
        if ({o_mem_req, o_err, o_stall} !== 3'b011) begin
            n_fail++;
            $display("FAIL misalign_err: got req/err/stall=%03b, required 011",
                     {o_mem_req, o_err, o_stall});
        end
        @(negedge clk);
        n_checks++;
        if ({o_mem_req, o_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL misalign_after: got req/err=%02b, required 00", {o_mem_req, o_err});
        end
`else
        exp_q.push_back('{chk: 1'b1, rdata: 32'hCAFEF00D});
        access(OpLw, 32'h101, 32'h0, 32'h3004, 1, 32'hCAFEF00D);
        n_checks++;
        if ({cap_req, cap_addr, cap_be, cap_done} !== {1'b1, 32'h100, 4'b1111, 1'b1}) begin
            n_fail++;
            $display("FAIL unaligned_lw: got req=%0b addr=%08h be=%04b done=%0b, required 1 00000100 1111 1",
                     cap_req, cap_addr, cap_be, cap_done);
        end
`endif
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        i_start = 1'b1; i_op = OpSw; i_addr = 32'h44; i_wdata = 32'h55AA55AA; i_pc = 32'h4000;
        repeat (2) @(negedge clk);
        i_start = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if ({o_mem_req, o_stall, o_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid: got req/stall/done=%03b, required 000",
                     {o_mem_req, o_stall, o_done});
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{chk: 1'b0, rdata: 32'h0});
        access(OpSw, 32'h50, 32'h12345678, 32'h4004, 1, 32'h0);
        n_checks++;
        if ({cap_req, cap_addr, cap_wdata, cap_done} !== {1'b1, 32'h50, 32'h12345678, 1'b1}) begin
            n_fail++;
            $display("FAIL sw_after_reset: got req=%0b addr=%08h wdata=%08h done=%0b, required 1 00000050 12345678 1",
                     cap_req, cap_addr, cap_wdata, cap_done);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_byte();
        test_half();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || err_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expectations: got %0d done and %0d err outstanding, required 0 0",
                     exp_q.size(), err_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

CPU-side initiator for data memory accesses in the MEM stage. Accepts one load/store per request from the pipeline, converts it into a word-aligned, byte-enabled request/acknowledge transaction toward the data memory, and stalls the pipeline until the memory acknowledges. Loads return data already byte-, halfword- or word-extracted and sign- or zero-extended. A missing acknowledge is reported as a bus error.

## Interface
- TIMEOUT, 255: maximum cycles spent waiting for `mem_ack` before a bus error is raised (1..65535).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pipeline request; sampled only in IDLE.
- op  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- addr  input  32  byte address.
- wdata  input  32  store data; low byte/halfword used for sb/sh.
- pc  input  32  PC of the access; captured for error reporting.
- stall  output  1  freeze the pipeline.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result; valid while `done` is high.
- err  output  1  one-cycle error pulse (timeout or misalignment).
- err_pc  output  32  PC of the faulting access; held until the next error.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write.
- mem_addr  output  32  `{addr[31:2],2'b00}`.
- mem_be  output  4  byte enables, little-endian (bit 0 = bits[7:0]).
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  memory acknowledge.
- mem_rdata  input  32  memory read word; valid with `mem_ack`.

## Operation
- States: IDLE, REQ, RESP, ERR.
- IDLE
  - `start`=1 captures op/addr/wdata/pc and goes to REQ.
  - If a misaligned access is detected (see Configuration), goes to ERR instead.
- REQ
  - `mem_req`=1. `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are driven from the captured registers and stay stable until `mem_ack`.
  - `mem_ack`=1 at a rising edge goes to RESP; for loads, `mem_rdata` is registered into `rdata` in the same edge.
  - The timeout counter increments on every REQ cycle without `mem_ack`. When it reaches TIMEOUT, go to ERR.
- RESP: `done`=1 for one cycle, then return to IDLE.
- ERR: `err`=1 for one cycle and `err_pc` is loaded, then return to IDLE. No `done` is issued for the failed access.
- Byte enables:
  - Word access: `mem_be`=1111.
  - Halfword: 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - Byte: `4'b0001 << addr[1:0]`.
  - Loads drive the same enables as stores.
- Store data: sb replicates `wdata[7:0]` into all 4 lanes; sh replicates `wdata[15:0]` into both halves; sw passes `wdata` through.
- Load extraction:
  - Select the lane indicated by `addr[1:0]`.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
- `start` outside IDLE is ignored. The pipeline holds its request while `stall` is high.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset value of every output is 0: `stall`, `done`, `rdata`, `err`, `err_pc`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`. State resets to IDLE and the timeout counter resets to 0.
- Reset mid-transaction drops `mem_req` immediately (asynchronous); the access is abandoned.
- `stall` = (IDLE & `start`) | REQ | ERR. It is combinational and is low in RESP.
- Latency with `start` at edge 0:
  - `mem_req` high after edge 0.
  - With ack sampled at edge k (k≥1), `done` and `rdata` are valid in the cycle after edge k.
  - Zero-wait memory: `done` in cycle 2.
- Timeout: with no ack, `err` is asserted in the cycle after TIMEOUT REQ cycles have elapsed. `mem_req` is low during ERR.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - lw/sw with `addr[1:0]`≠0, or lh/lhu/sh with `addr[0]`=1, issue no memory request.
  - IDLE goes directly to ERR: `err` pulses in the cycle after `start` and `err_pc`=pc.
- Undefined:
  - No alignment check.
  - Word ops ignore `addr[1:0]`; halfword ops ignore `addr[0]`.

## Test plan
- sw addr=0x10, wdata=0xDEADBEEF, memory acks in 1st REQ cycle -> `mem_addr`=0x10, `mem_be`=1111, `mem_we`=1, `done` in cycle 2, `stall` high in cycles 0-1.
- sb addr=0x13, wdata=0x000000A5 -> `mem_be`=1000, `mem_wdata`=0xA5A5A5A5. Then lb addr=0x13, `mem_rdata`=0xA5000000 -> `rdata`=0xFFFFFFA5; lbu of the same access -> `rdata`=0x000000A5.
- lh addr=0x22, `mem_rdata`=0x8001_1234, ack delayed 3 cycles -> `mem_be`=1100, request fields stable for all 3 wait cycles, `rdata`=0xFFFF8001; lhu -> 0x00008001.
- TIMEOUT=4, no ack, pc=0x3000 -> `err` pulses after 4 REQ cycles, `err_pc`=0x3000, no `done`, `mem_req` low during ERR and then back in IDLE.
- With `MEM_ALIGN_CHECK_EN` defined, lw addr=0x101, pc=0x3004 -> `mem_req` never asserted, `err` in cycle 1, `err_pc`=0x3004. Without the macro -> normal read of `mem_addr`=0x100.
- Assert `rst` in the 2nd REQ cycle -> `mem_req`, `stall` and `done` go to 0 immediately. A subsequent sw after reset completes normally.
